// File: rtl/global_constants.sv
// Shared constants for the speed-arbiter slice: default channel count,
// speed width, the arbiter state encoding and a small index helper.
package global_constants;

  localparam int N_CHAN  = 4;
  localparam int SPEED_W = 32;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } arb_state_e;

  // (base + offset) mod modulus for non-negative operands
  function automatic int wrap_add(input int base, input int offset, input int modulus);
    int sum;
    sum = base + offset;
    return sum % modulus;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first pending channel at or above rr_ptr,
// wrapping around modulo N_CHAN. Purely combinational.
module rr_pick #(
  parameter int N_CHAN = 4,
  parameter int IDX_W  = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
  input  logic [N_CHAN-1:0] pending,
  input  logic [IDX_W-1:0]  rr_ptr,
  output logic [IDX_W-1:0]  winner,
  output logic              any_pending
);

  import global_constants::wrap_add;

  logic [IDX_W-1:0] idx_s;

  // Scan upward from rr_ptr; the first pending channel found wins
  always_comb begin
    winner      = '0;
    any_pending = 1'b0;
    idx_s       = '0;
    for (int k = 0; k < N_CHAN; k++) begin
      idx_s = IDX_W'(wrap_add(int'(rr_ptr), k, N_CHAN));
      if (!any_pending && pending[idx_s]) begin
        winner      = idx_s;
        any_pending = 1'b1;
      end else begin
        any_pending = any_pending;
      end
    end
  end

endmodule

// File: rtl/qe_speed_arbiter.sv
// Speed-measurement write arbiter: N_CHAN channels buffer their latest
// speed value and share a single register-bank write port. A two-state
// FSM grants channels round-robin and holds the write until wr_ready.
module qe_speed_arbiter #(
  parameter int N_CHAN  = global_constants::N_CHAN,
  parameter int SPEED_W = global_constants::SPEED_W,
  parameter int IDX_W   = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_CHAN-1:0]           req,
  input  logic [N_CHAN*SPEED_W-1:0]   speed_in,
  input  logic                        wr_ready,
  input  logic [N_CHAN-1:0]           clear_overrun,
  output logic                        wr_en,
  output logic [IDX_W-1:0]            wr_addr,
  output logic [SPEED_W-1:0]          wr_data,
  output logic [N_CHAN-1:0]           overrun
);

  import global_constants::arb_state_e;
  import global_constants::S_IDLE;
  import global_constants::S_WRITE;
  import global_constants::wrap_add;

  arb_state_e           state_r;
  logic [IDX_W-1:0]     grant_idx_r;
  logic [IDX_W-1:0]     rr_ptr_r;
  logic                 wr_en_r;
  logic [IDX_W-1:0]     wr_addr_r;
  logic [SPEED_W-1:0]   wr_data_r;
  // The granted channel received a new value after its grant; that value
  // still needs its own write once the in-flight one completes.
  logic                 fresh_r;

  logic [N_CHAN-1:0]    pending_r;
  logic [N_CHAN-1:0]    overrun_r;
  logic [SPEED_W-1:0]   hold_r [N_CHAN];

  logic [IDX_W-1:0]     winner_s;
  logic                 any_pending_s;
  logic                 transfer_s;
  logic [N_CHAN-1:0]    complete_s;
  logic [N_CHAN-1:0]    clean_s;
  logic [N_CHAN-1:0]    ovr_set_s;

  rr_pick #(
    .N_CHAN (N_CHAN),
    .IDX_W  (IDX_W)
  ) u_rr_pick (
    .pending     (pending_r),
    .rr_ptr      (rr_ptr_r),
    .winner      (winner_s),
    .any_pending (any_pending_s)
  );

  // Per-channel completion and overrun qualification for this cycle
  always_comb begin
    transfer_s = (state_r == S_WRITE) && wr_ready;
    complete_s = '0;
    clean_s    = '0;
    ovr_set_s  = '0;
    for (int i = 0; i < N_CHAN; i++) begin
      complete_s[i] = transfer_s && (grant_idx_r == IDX_W'(i));
      // Hold value already copied into the write register: replacing it loses nothing
      clean_s[i]    = (state_r == S_WRITE) && (grant_idx_r == IDX_W'(i)) && !fresh_r;
      ovr_set_s[i]  = req[i] && pending_r[i] && !complete_s[i] && !clean_s[i];
    end
  end

  // Channel hold registers, pending flags and sticky overrun flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_r <= '0;
      overrun_r <= '0;
      for (int i = 0; i < N_CHAN; i++) begin
        hold_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CHAN; i++) begin
        if (req[i]) begin
          hold_r[i]    <= speed_in[i*SPEED_W +: SPEED_W];
          pending_r[i] <= 1'b1;
        end else if (complete_s[i]) begin
          pending_r[i] <= fresh_r;
        end else begin
          pending_r[i] <= pending_r[i];
        end
        if (ovr_set_s[i]) begin
          overrun_r[i] <= 1'b1;
        end else if (clear_overrun[i]) begin
          overrun_r[i] <= 1'b0;
        end else begin
          overrun_r[i] <= overrun_r[i];
        end
      end
    end
  end

  // Grant/write FSM with registered write-port outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= S_IDLE;
      grant_idx_r <= '0;
      rr_ptr_r    <= '0;
      wr_en_r     <= 1'b0;
      wr_addr_r   <= '0;
      wr_data_r   <= '0;
      fresh_r     <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (any_pending_s) begin
            grant_idx_r <= winner_s;
            wr_addr_r   <= winner_s;
            wr_data_r   <= hold_r[winner_s];
            wr_en_r     <= 1'b1;
            fresh_r     <= 1'b0;
            state_r     <= S_WRITE;
          end else begin
            state_r     <= S_IDLE;
          end
        end
        S_WRITE: begin
          if (wr_ready) begin
            wr_en_r  <= 1'b0;
            fresh_r  <= 1'b0;
            rr_ptr_r <= IDX_W'(wrap_add(int'(grant_idx_r), 1, N_CHAN));
            state_r  <= S_IDLE;
          end else if (req[grant_idx_r]) begin
            fresh_r  <= 1'b1;
          end else begin
            state_r  <= S_WRITE;
          end
        end
        default: begin
          wr_en_r <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign wr_en   = wr_en_r;
  assign wr_addr = wr_addr_r;
  assign wr_data = wr_data_r;
  assign overrun = overrun_r;

endmodule

// File: doc/qe_speed_arbiter.md
QE_SPEED_ARBITER -- requirements
Module: qe_speed_arbiter

Interface
REQ-001 Parameter N_CHAN, default 4, number of speed-measurement channels sharing one write port.
REQ-002 Parameter SPEED_W, default 32, width of a speed value.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req  input  N_CHAN  per-channel single-cycle strobe: the channel's speed buffer has a new value.
REQ-006 speed_in  input  N_CHAN x SPEED_W  per-channel speed value, valid in the cycle its req bit is high.
REQ-007 wr_ready  input  1  register bank accepts the write this cycle.
REQ-008 clear_overrun  input  N_CHAN  per-channel clear of the sticky overrun flag.
REQ-009 wr_en  output  1  write request to the register bank.
REQ-010 wr_addr  output  clog2(N_CHAN)  channel index of the write.
REQ-011 wr_data  output  SPEED_W  speed value being written.
REQ-012 overrun  output  N_CHAN  sticky flag: a channel value was replaced before it was written.

Function
REQ-013 Each channel SHALL have a pending flag and a SPEED_W hold register; req[i]=1 loads speed_in[i] into hold[i] and sets pending[i] at the next edge.
REQ-014 The FSM SHALL have exactly two states, S_IDLE and S_WRITE; the reset state is S_IDLE.
REQ-015 In S_IDLE with any pending bit set, the FSM SHALL latch the round-robin winner into grant_idx, latch hold[winner] into the write-data register, and move to S_WRITE; otherwise it SHALL stay in S_IDLE.
REQ-016 Round-robin SHALL search upward from rr_ptr and wrap modulo N_CHAN; after each completed transfer, rr_ptr = grant_idx+1 mod N_CHAN.
REQ-017 In S_WRITE, wr_en=1, wr_addr=grant_idx, and wr_data SHALL be the latched value, held stable until the transfer completes.
REQ-018 A transfer occurs in a cycle with wr_en=1 and wr_ready=1; the FSM then clears pending[grant_idx] and returns to S_IDLE.
REQ-019 wr_ready=0 in S_WRITE SHALL hold the state and all outputs unchanged, with no timeout.
REQ-020 Latency: with the block idle and nothing else pending, wr_en SHALL rise 2 cycles after the req pulse; sustained throughput is at most one write per 2 cycles.
REQ-021 req[i] while pending[i]=1 and channel i is not completing a transfer that cycle: hold[i] takes the new value, pending stays 1, overrun[i] is set.
REQ-022 req[i] in the same cycle as the transfer of channel i: hold[i] takes the new value, pending[i] stays 1, overrun is not set, and the in-flight write keeps its old latched value.
REQ-023 req[i] arriving after channel i was granted, but before its transfer, SHALL update hold[i] only; the in-flight wr_data SHALL NOT change.
REQ-024 clear_overrun[i] and an overrun-setting event in the same cycle: set wins.
REQ-025 When all channels are pending, each SHALL be written exactly once before any channel is written twice.

Reset
REQ-026 Reset SHALL force state=S_IDLE, pending=0, overrun=0, rr_ptr=0, grant_idx=0, hold registers=0, wr_en=0, wr_addr=0, wr_data=0.
REQ-027 Reset asserted mid-transfer SHALL drop wr_en in the same cycle (asynchronously) and discard all pending values.

Structure
REQ-028 N_CHAN, SPEED_W and the state enum SHALL reside in global_constants.sv.
REQ-029 The round-robin search SHALL be a separate combinational sub-module rr_pick (inputs pending and rr_ptr; outputs winner index and any_pending).

Verification
REQ-030 Idle, req[2] pulse with speed_in[2]=0x0000_1234, wr_ready=1 -> wr_en high 2 cycles later with wr_addr=2 and wr_data=0x1234 for 1 cycle; pending[2] then 0.
REQ-031 req=4'b1111 in one cycle, wr_ready=1 -> writes to addresses 0,1,2,3 in order, one every 2 cycles; overrun=0.
REQ-032 wr_ready=0 for 10 cycles during a write of channel 1 -> wr_en, wr_addr and wr_data stable for the whole stall; a req[1] with value 0x55 during the stall -> old data written, then a second write of 0x55, overrun[1]=0.
REQ-033 req[3] twice (values 0xA, then 0xB) while channel 0 is stalled -> one write of 0xB to channel 3, overrun[3]=1; clear_overrun[3] -> overrun[3]=0 on the next cycle.
REQ-034 reset pulsed low while wr_en=1 and wr_ready=0 -> wr_en=0 immediately, and no write occurs after reset is released.
